// File: rtl/siacore_pkg.sv
// Shared constants and helpers for the Sia Blake2b-256 header search core.
// Holds the Blake2b IV, sigma schedule, rotation amounts and the controller state enum.
package siacore_pkg;

  localparam int ROUNDS  = 12;
  localparam int HDR_LEN = 80;

  localparam int unsigned ROT_A = 32;
  localparam int unsigned ROT_B = 24;
  localparam int unsigned ROT_C = 16;
  localparam int unsigned ROT_D = 63;

  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Parameter block for an unkeyed 32-byte digest folded into h0.
  localparam logic [63:0] H0_INIT = IV[0] ^ 64'h0000_0000_0101_0020;

  // One row per round, most significant nibble is message position 0.
  localparam logic [63:0] SIGMA [10] = '{
    64'h0123456789ABCDEF, 64'hEA489FD61C02B753,
    64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19,
    64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
  };

  typedef enum logic [1:0] {IDLE, INIT, ROUND, CHECK} state_e;

  function automatic logic [3:0] sigmaSel(input logic [3:0] row, input logic [3:0] pos);
    logic [63:0] r;
    r = SIGMA[row];
    return r[{4'd15 - pos, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/siacore_g.sv
// Blake2b G mixing function: four state words and two message words in, four words out.
module siacore_g
  import siacore_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] c_i,
  input  logic [63:0] d_i,
  input  logic [63:0] x_i,
  input  logic [63:0] y_i,
  output logic [63:0] a_o,
  output logic [63:0] b_o,
  output logic [63:0] c_o,
  output logic [63:0] d_o
);

  logic [63:0] a1, b1, c1, d1;

  assign a1  = a_i + b_i + x_i;
  assign d1  = ror64(d_i ^ a1, ROT_A);
  assign c1  = c_i + d1;
  assign b1  = ror64(b_i ^ c1, ROT_B);
  assign a_o = a1 + b1 + y_i;
  assign d_o = ror64(d1 ^ a_o, ROT_C);
  assign c_o = c1 + d_o;
  assign b_o = ror64(b1 ^ c_o, ROT_D);

endmodule

// File: rtl/siacore.sv
// Sia header search core: one Blake2b round per cycle, 14 cycles per nonce tried.
// Define SIACORE_WRAP_STOP_EN to stop (instead of wrapping) after a miss on nonce field 32'hFFFF_FFFF.
module siacore
  import siacore_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [639:0] work,
  input  logic [63:0]  target,
  input  logic         valid,
  output logic         found,
  output logic [31:0]  nonce,
  output logic         busy
);

  state_e        state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [63:0]   v_q [16];
  logic [63:0]   v_d [16];
  logic [639:0]  work_q, work_d;
  logic [63:0]   target_q, target_d;
  logic          found_q, found_d;
  logic [31:0]   nonce_q, nonce_d;

  logic [63:0]   msg [16];
  logic [63:0]   vMid [16];
  logic [63:0]   vRound [16];
  logic [3:0]    rowSel;
  logic [63:0]   hash0;
  logic          hit;

  // The nonce field lives inside work_q itself and is incremented in place.
  always_comb begin
    for (int i = 0; i < 16; i++) msg[i] = '0;
    for (int i = 0; i < 10; i++) msg[i] = work_q[64*i +: 64];
  end

  assign rowSel = (rnd_q >= 4'd10) ? rnd_q - 4'd10 : rnd_q;

  for (genvar j = 0; j < 4; j++) begin : gCol
    siacore_g uG (
      .a_i(v_q[j]), .b_i(v_q[j+4]), .c_i(v_q[j+8]), .d_i(v_q[j+12]),
      .x_i(msg[sigmaSel(rowSel, 4'(2*j))]), .y_i(msg[sigmaSel(rowSel, 4'(2*j+1))]),
      .a_o(vMid[j]), .b_o(vMid[j+4]), .c_o(vMid[j+8]), .d_o(vMid[j+12])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : gDiag
    localparam int BI = 4 + ((j + 1) % 4);
    localparam int CI = 8 + ((j + 2) % 4);
    localparam int DI = 12 + ((j + 3) % 4);
    siacore_g uG (
      .a_i(vMid[j]), .b_i(vMid[BI]), .c_i(vMid[CI]), .d_i(vMid[DI]),
      .x_i(msg[sigmaSel(rowSel, 4'(8+2*j))]), .y_i(msg[sigmaSel(rowSel, 4'(9+2*j))]),
      .a_o(vRound[j]), .b_o(vRound[BI]), .c_o(vRound[CI]), .d_o(vRound[DI])
    );
  end

  assign hash0 = H0_INIT ^ v_q[0] ^ v_q[8];
  assign hit   = (bswap64(hash0) <= target_q);

  // A new valid always wins, which also silently discards any search in flight.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    v_d      = v_q;
    work_d   = work_q;
    target_d = target_q;
    found_d  = 1'b0;
    nonce_d  = nonce_q;
    if (valid) begin
      work_d   = work;
      target_d = target;
      state_d  = INIT;
    end else begin
      case (state_q)
        INIT: begin
          v_d[0] = H0_INIT;
          for (int i = 1; i < 8; i++) v_d[i] = IV[i];
          for (int i = 0; i < 8; i++) v_d[8+i] = IV[i];
          v_d[12] = IV[4] ^ 64'(HDR_LEN);
          v_d[14] = ~IV[6];
          rnd_d   = '0;
          state_d = ROUND;
        end
        ROUND: begin
          v_d = vRound;
          if (rnd_q == 4'(ROUNDS - 1)) state_d = CHECK;
          else rnd_d = rnd_q + 4'd1;
        end
        CHECK: begin
          if (hit) begin
            found_d = 1'b1;
            nonce_d = bswap32(work_q[287:256]);
            state_d = IDLE;
          end else begin
            work_d[287:256] = work_q[287:256] + 32'd1;
            state_d         = INIT;
`ifdef SIACORE_WRAP_STOP_EN
            if (work_q[287:256] == 32'hFFFF_FFFF) state_d = IDLE;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      for (int i = 0; i < 16; i++) v_q[i] <= '0;
      work_q   <= '0;
      target_q <= '0;
      found_q  <= 1'b0;
      nonce_q  <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      v_q      <= v_d;
      work_q   <= work_d;
      target_q <= target_d;
      found_q  <= found_d;
      nonce_q  <= nonce_d;
    end
  end

  assign found = found_q;
  assign nonce = nonce_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_siacore.sv
// Directed bench for siacore; expected hashes come from a behavioural Blake2b-256 reference.
module tb_siacore;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [639:0] work;
  logic [63:0]  target;
  logic         valid;
  logic         found;
  logic [31:0]  nonce;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] iv [8];
  int          sig [10][16];
  logic [63:0] mv [16];

  siacore dut (
    .clk(clk), .rst_n(rst_n), .work(work), .target(target),
    .valid(valid), .found(found), .nonce(nonce), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] bs32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic void gMix(input int a, input int b, input int c, input int d,
                               input logic [63:0] x, input logic [63:0] y);
    mv[a] = mv[a] + mv[b] + x;  mv[d] = rotr(mv[d] ^ mv[a], 32);
    mv[c] = mv[c] + mv[d];      mv[b] = rotr(mv[b] ^ mv[c], 24);
    mv[a] = mv[a] + mv[b] + y;  mv[d] = rotr(mv[d] ^ mv[a], 16);
    mv[c] = mv[c] + mv[d];      mv[b] = rotr(mv[b] ^ mv[c], 63);
  endfunction

  // Returns the first digest word, byte-reversed, for header w with nonce field f.
  function automatic logic [63:0] hashVal(input logic [639:0] w, input logic [31:0] f);
    logic [63:0] m [16];
    logic [63:0] h0, hw, r;
    int ga [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int gc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int gd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    for (int i = 0; i < 16; i++) m[i] = (i < 10) ? w[64*i +: 64] : 64'd0;
    m[4][31:0] = f;
    h0 = iv[0] ^ 64'h0101_0020;
    mv[0] = h0;
    for (int i = 1; i < 8; i++) mv[i] = iv[i];
    for (int i = 0; i < 8; i++) mv[8+i] = iv[i];
    mv[12] = mv[12] ^ 64'd80;
    mv[14] = ~mv[14];
    for (int rr = 0; rr < 12; rr++)
      for (int j = 0; j < 8; j++)
        gMix(ga[j], gb[j], gc[j], gd[j], m[sig[rr % 10][2*j]], m[sig[rr % 10][2*j+1]]);
    hw = h0 ^ mv[0] ^ mv[8];
    for (int i = 0; i < 8; i++) r[8*i +: 8] = hw[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [639:0] makeHeader(input int seed);
    logic [639:0] h;
    logic [31:0]  s;
    s = 32'(seed);
    for (int i = 0; i < 10; i++)
      h[64*i +: 64] = {s * 32'h9E37_79B9 + 32'(i), 32'h5141_0000 ^ (s + 32'(i) * 32'd17)};
    return h;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Call at a falling edge; valid is sampled by the next rising edge.
  task automatic applyStimulus(input logic [639:0] w, input logic [63:0] t);
    work   = w;
    target = t;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic waitFound(input int budget, output int cycles, output logic [31:0] seen);
    cycles = -1;
    seen   = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (found === 1'b1) begin
        cycles = i;
        seen   = nonce;
        checkOutput("busyWithFound", 64'(busy), 64'd0);
        break;
      end
    end
  endtask

  task automatic countPulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      if (found === 1'b1) p++;
    end
  endtask

  initial begin
    logic [639:0] hdr;
    logic [63:0]  vals [4];
    logic [63:0]  tgt;
    logic [31:0]  fld, base, seen;
    int           cyc, p, p2, k;
    bit           picked;

    iv = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
           64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    sig = '{'{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
            '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
            '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
            '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
            '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
            '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
            '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
            '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
            '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
            '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}};

    valid = 1'b0; work = '0; target = '0; rst_n = 1'b0;
    #12;
    checkOutput("rstFound", 64'(found), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstNonce", 64'(nonce), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Always-hit target: first nonce wins after 14 cycles.
    hdr = makeHeader(1);
    hdr[287:256] = 32'h1234_5678;
    applyStimulus(hdr, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("busyAfterValid", 64'(busy), 64'd1);
    waitFound(40, cyc, seen);
    checkOutput("easyLatency", 64'(cyc), 64'd14);
    checkOutput("easyNonce", 64'(seen), 64'h7856_3412);
    countPulses(5, p);
    checkOutput("easyExtraPulses", 64'(p), 64'd0);
    checkOutput("easyBusyAfter", 64'(busy), 64'd0);

    // Pick a start field whose fourth candidate is the first to meet its own hash as target.
    hdr = makeHeader(2);
    picked = 1'b0;
    base = '0;
    for (int b = 0; b < 64 && !picked; b++) begin
      base = 32'h0BAD_0000 + 32'(b);
      for (int j = 0; j < 4; j++) vals[j] = hashVal(hdr, base + 32'(j));
      if (vals[3] < vals[0] && vals[3] < vals[1] && vals[3] < vals[2]) picked = 1'b1;
    end
    checkOutput("goldenSearch", 64'(picked), 64'd1);
    hdr[287:256] = base;
    applyStimulus(hdr, vals[3]);
    waitFound(80, cyc, seen);
    checkOutput("goldenLatency", 64'(cyc), 64'd56);
    checkOutput("goldenNonce", 64'(seen), 64'(bs32(base + 32'd3)));
    countPulses(20, p);
    checkOutput("goldenExtraPulses", 64'(p), 64'd0);

    // Ten searches back to back, each started the cycle after the previous found.
    for (int t = 0; t < 10; t++) begin
      hdr = makeHeader(10 + t);
      fld = 32'hC000_0000 + 32'(t) * 32'h0101_0101;
      tgt = hashVal(hdr, fld + 32'd1);
      k   = (hashVal(hdr, fld) <= tgt) ? 0 : 1;
      hdr[287:256] = fld;
      applyStimulus(hdr, tgt);
      waitFound(40, cyc, seen);
      checkOutput($sformatf("b2bLatency%0d", t), 64'(cyc), 64'(14 * (k + 1)));
      checkOutput($sformatf("b2bNonce%0d", t), 64'(seen), 64'(bs32(fld + 32'(k))));
    end
    @(negedge clk);

    // Abort an impossible search at cycle 20 with new work.
    hdr = makeHeader(30);
    hdr[287:256] = 32'h0000_1000;
    applyStimulus(hdr, 64'd0);
    countPulses(19, p);
    checkOutput("abortNoEarlyFound", 64'(p), 64'd0);
    hdr = makeHeader(31);
    hdr[287:256] = 32'hDEAD_BEEF;
    applyStimulus(hdr, 64'hFFFF_FFFF_FFFF_FFFF);
    waitFound(40, cyc, seen);
    checkOutput("abortLatency", 64'(cyc), 64'd14);
    checkOutput("abortNonce", 64'(seen), 64'hEFBE_ADDE);

    // Asynchronous reset in the middle of cycle 7 of a search.
    hdr = makeHeader(40);
    hdr[287:256] = 32'h0000_0777;
    applyStimulus(hdr, 64'd0);
    countPulses(6, p);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstFound", 64'(found), 64'd0);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstNonce", 64'(nonce), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    countPulses(30, p);
    checkOutput("postRstPulses", 64'(p), 64'd0);
    checkOutput("postRstBusy", 64'(busy), 64'd0);

    // Miss on the last field value.
    hdr = makeHeader(50);
    hdr[287:256] = 32'hFFFF_FFFF;
`ifdef SIACORE_WRAP_STOP_EN
    applyStimulus(hdr, 64'd0);
    countPulses(13, p);
    checkOutput("wrapBusyBeforeStop", 64'(busy), 64'd1);
    countPulses(1, p2);
    checkOutput("wrapBusyStopped", 64'(busy), 64'd0);
    countPulses(20, k);
    checkOutput("wrapNoFound", 64'(p + p2 + k), 64'd0);
`else
    tgt = hashVal(hdr, 32'd0);
    k   = (hashVal(hdr, 32'hFFFF_FFFF) <= tgt) ? 0 : 1;
    applyStimulus(hdr, tgt);
    waitFound(40, cyc, seen);
    fld = 32'hFFFF_FFFF + 32'(k);
    checkOutput("wrapLatency", 64'(cyc), 64'(14 * (k + 1)));
    checkOutput("wrapNonce", 64'(seen), 64'(bs32(fld)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
